// File: rtl/sift_det_pkg.sv
// Shared constants and state encoding for the DoG extremum detector.
package sift_det_pkg;

  localparam int DATA_W   = 8;                  // DoG sample width
  localparam int NUM_NBR  = 26;                 // neighbours in a 3x3x3 cube
  localparam int NUM_GRP  = (NUM_NBR + 2) / 3;  // groups of three neighbours
  localparam int GRP_W    = $clog2(NUM_GRP);
  localparam int NUM_SLOT = NUM_GRP * 3;        // neighbour slots incl. padding
  localparam int SLOT_W   = $clog2(NUM_SLOT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Flat slot index of lane (0..2) within group grp.
  function automatic logic [SLOT_W-1:0] slot_idx(input logic [GRP_W-1:0] grp,
                                                 input logic [1:0]       lane);
    return SLOT_W'(grp) * SLOT_W'(3) + SLOT_W'(lane);
  endfunction

endpackage

// File: rtl/nbr_group_mux.sv
// Selects the three neighbours of one comparator group. Slots past the last
// real neighbour carry the centre value, which passes both <= and >= tests.
module nbr_group_mux
  import sift_det_pkg::*;
(
  input  logic [GRP_W-1:0]          grp,
  input  logic [DATA_W-1:0]         center,
  input  logic [NUM_NBR*DATA_W-1:0] nbr,
  output logic [DATA_W-1:0]         b0,
  output logic [DATA_W-1:0]         b1,
  output logic [DATA_W-1:0]         b2
);

  logic [DATA_W-1:0] slot_s [NUM_SLOT];
  logic [SLOT_W-1:0] idx0_s;
  logic [SLOT_W-1:0] idx1_s;
  logic [SLOT_W-1:0] idx2_s;

  genvar k;
  generate
    for (k = 0; k < NUM_SLOT; k++) begin : g_slot
      if (k < NUM_NBR) begin : g_real
        assign slot_s[k] = nbr[k*DATA_W +: DATA_W];
      end else begin : g_pad
        assign slot_s[k] = center;
      end
    end
  endgenerate

  assign idx0_s = slot_idx(grp, 2'd0);
  assign idx1_s = slot_idx(grp, 2'd1);
  assign idx2_s = slot_idx(grp, 2'd2);

  // Lane select; an out-of-range group falls back to the neutral centre value.
  always_comb begin
    b0 = center;
    b1 = center;
    b2 = center;
    if (idx0_s < SLOT_W'(NUM_SLOT)) b0 = slot_s[idx0_s];
    else                            b0 = center;
    if (idx1_s < SLOT_W'(NUM_SLOT)) b1 = slot_s[idx1_s];
    else                            b1 = center;
    if (idx2_s < SLOT_W'(NUM_SLOT)) b2 = slot_s[idx2_s];
    else                            b2 = center;
  end

endmodule

// File: rtl/extrema_cmp_scheduler.sv
// Sequences one 3x3x3 DoG extremum test through shared registered 1-vs-3
// min/max comparators: 9 groups issued back to back, flags ANDed as they
// return one cycle later, result strobed 11 cycles after accept.
module extrema_cmp_scheduler
  import sift_det_pkg::*;
(
  input  logic                      iclk,
  input  logic                      irst,
  input  logic                      iValid,
  output logic                      oReady,
  input  logic [DATA_W-1:0]         iCenter,
  input  logic [NUM_NBR*DATA_W-1:0] iNbr,
  output logic [DATA_W-1:0]         oCmp_a,
  output logic [DATA_W-1:0]         oCmp_b0,
  output logic [DATA_W-1:0]         oCmp_b1,
  output logic [DATA_W-1:0]         oCmp_b2,
  input  logic                      iSmall_en,
  input  logic                      iBig_en,
  output logic                      oValid,
  output logic                      oIsMin,
  output logic                      oIsMax
);

  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GRP - 1);

  state_e                    state_q,   state_d;
  logic [GRP_W-1:0]          grp_q,     grp_d;
  logic [DATA_W-1:0]         center_q,  center_d;
  logic [NUM_NBR*DATA_W-1:0] nbr_q,     nbr_d;
  logic                      acc_min_q, acc_min_d;
  logic                      acc_max_q, acc_max_d;
  logic                      valid_q,   valid_d;
  logic                      is_min_q,  is_min_d;
  logic                      is_max_q,  is_max_d;

  logic [DATA_W-1:0]         mux_b0_s;
  logic [DATA_W-1:0]         mux_b1_s;
  logic [DATA_W-1:0]         mux_b2_s;

  nbr_group_mux u_mux (
    .grp    (grp_q),
    .center (center_q),
    .nbr    (nbr_q),
    .b0     (mux_b0_s),
    .b1     (mux_b1_s),
    .b2     (mux_b2_s)
  );

  // State, group counter, captured candidate, accumulators and result registers.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q   <= IDLE;
      grp_q     <= '0;
      center_q  <= '0;
      nbr_q     <= '0;
      acc_min_q <= 1'b0;
      acc_max_q <= 1'b0;
      valid_q   <= 1'b0;
      is_min_q  <= 1'b0;
      is_max_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      center_q  <= center_d;
      nbr_q     <= nbr_d;
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      valid_q   <= valid_d;
      is_min_q  <= is_min_d;
      is_max_q  <= is_max_d;
    end
  end

  // Next-state logic: capture on accept, step groups, fold in returning flags.
  // The flag seen in the first ISSUE cycle answers no group and is skipped.
  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    center_d  = center_q;
    nbr_d     = nbr_q;
    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    valid_d   = 1'b0;
    is_min_d  = is_min_q;
    is_max_d  = is_max_q;
    case (state_q)
      IDLE: begin
        if (iValid) begin
          state_d   = ISSUE;
          grp_d     = '0;
          center_d  = iCenter;
          nbr_d     = iNbr;
          acc_min_d = 1'b1;
          acc_max_d = 1'b1;
        end else begin
          state_d   = IDLE;
        end
      end
      ISSUE: begin
        if (grp_q != '0) begin
          acc_min_d = acc_min_q & iSmall_en;
          acc_max_d = acc_max_q & iBig_en;
        end else begin
          acc_min_d = acc_min_q;
          acc_max_d = acc_max_q;
        end
        if (grp_q == LAST_GRP) begin
          state_d = DRAIN;
          grp_d   = '0;
        end else begin
          state_d = ISSUE;
          grp_d   = grp_q + GRP_W'(1);
        end
      end
      DRAIN: begin
        acc_min_d = acc_min_q & iSmall_en;
        acc_max_d = acc_max_q & iBig_en;
        valid_d   = 1'b1;
        is_min_d  = acc_min_q & iSmall_en;
        is_max_d  = acc_max_q & iBig_en;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Comparator operands are driven only while issuing, zero otherwise.
  always_comb begin
    oCmp_a  = '0;
    oCmp_b0 = '0;
    oCmp_b1 = '0;
    oCmp_b2 = '0;
    if (state_q == ISSUE) begin
      oCmp_a  = center_q;
      oCmp_b0 = mux_b0_s;
      oCmp_b1 = mux_b1_s;
      oCmp_b2 = mux_b2_s;
    end else begin
      oCmp_a  = '0;
      oCmp_b0 = '0;
      oCmp_b1 = '0;
      oCmp_b2 = '0;
    end
  end

  assign oReady = (state_q == IDLE);
  assign oValid = valid_q;
  assign oIsMin = is_min_q;
  assign oIsMax = is_max_q;

endmodule

// File: tb/tb_extrema_cmp_scheduler.sv
// Directed bench for extrema_cmp_scheduler with 1-cycle registered min/max
// comparator models attached to the operand outputs.
module tb_extrema_cmp_scheduler;
  import sift_det_pkg::*;

  localparam int DW = DATA_W;
  localparam int NN = NUM_NBR;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 iValid;
  logic                 oReady;
  logic [DW-1:0]        iCenter;
  logic [NN*DW-1:0]     iNbr;
  logic [DW-1:0]        oCmp_a, oCmp_b0, oCmp_b1, oCmp_b2;
  logic                 iSmall_en = 1'b0;
  logic                 iBig_en   = 1'b0;
  logic                 oValid, oIsMin, oIsMax;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] cap_a [9];
  logic [DW-1:0] cap_b [9][3];
  int            vcyc, vcount, rlow;
  logic          cap_min, cap_max;
  int            np;
  int            pc [2];
  logic          pmin [2];
  logic          pmax [2];

  always #5 clk = ~clk;

  extrema_cmp_scheduler dut (
    .iclk      (clk),
    .irst      (rst),
    .iValid    (iValid),
    .oReady    (oReady),
    .iCenter   (iCenter),
    .iNbr      (iNbr),
    .oCmp_a    (oCmp_a),
    .oCmp_b0   (oCmp_b0),
    .oCmp_b1   (oCmp_b1),
    .oCmp_b2   (oCmp_b2),
    .iSmall_en (iSmall_en),
    .iBig_en   (iBig_en),
    .oValid    (oValid),
    .oIsMin    (oIsMin),
    .oIsMax    (oIsMax)
  );

  // Registered comparator models: flags appear one cycle after operands.
  always @(posedge clk) begin
    iSmall_en <= (oCmp_a <= oCmp_b0) && (oCmp_a <= oCmp_b1) && (oCmp_a <= oCmp_b2);
    iBig_en   <= (oCmp_a >= oCmp_b0) && (oCmp_a >= oCmp_b1) && (oCmp_a >= oCmp_b2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [DW-1:0] c, input logic [DW-1:0] v);
    iCenter = c;
    for (int k = 0; k < NN; k++) iNbr[k*DW +: DW] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers the current candidate, then observes cycles T+1..T+12.
  task automatic run_one();
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    vcyc = 0; vcount = 0; rlow = 0; cap_min = 1'b0; cap_max = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 9) begin
        cap_a[c-1]    = oCmp_a;
        cap_b[c-1][0] = oCmp_b0;
        cap_b[c-1][1] = oCmp_b1;
        cap_b[c-1][2] = oCmp_b2;
      end
      if (!oReady) rlow++;
      if (oValid) begin
        vcount++;
        vcyc    = c;
        cap_min = oIsMin;
        cap_max = oIsMax;
      end
      if (c < 12) step();
    end
  endtask

  task automatic check_result(input string t, input logic emin, input logic emax);
    check({t, "_lat"},    32'(vcyc),    32'd11);
    check({t, "_pulses"}, 32'(vcount),  32'd1);
    check({t, "_rlow"},   32'(rlow),    32'd11);
    check({t, "_min"},    32'(cap_min), 32'(emin));
    check({t, "_max"},    32'(cap_max), 32'(emax));
  endtask

  initial begin
    rst = 1'b1; iValid = 1'b0; iCenter = '0; iNbr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  32'(oReady), 32'd1);
    check("rst_valid",  32'(oValid), 32'd0);
    check("rst_min",    32'(oIsMin), 32'd0);
    check("rst_max",    32'(oIsMax), 32'd0);
    check("rst_cmp_a",  32'(oCmp_a), 32'd0);
    rst = 1'b0;
    step();

    // 1: strict local minimum
    fill(8'd10, 8'd20);
    run_one();
    check_result("t1", 1'b1, 1'b0);
    check("t1_a_g0",  32'(cap_a[0]),    32'd10);
    check("t1_b0_g0", 32'(cap_b[0][0]), 32'd20);

    // 2: maximum with one tie and the padded slot
    fill(8'd200, 8'd100);
    iNbr[25*DW +: DW] = 8'd200;
    run_one();
    check_result("t2", 1'b0, 1'b1);
    check("t2_b1_g8", 32'(cap_b[8][1]), 32'd200);
    check("t2_b2_g8", 32'(cap_b[8][2]), 32'd200);

    // 3: neither extremum; one smaller neighbour in group 4
    fill(8'd50, 8'd60);
    iNbr[13*DW +: DW] = 8'd49;
    run_one();
    check_result("t3", 1'b0, 1'b0);
    check("t3_b1_g4", 32'(cap_b[4][1]), 32'd49);
    check("t3_a_g4",  32'(cap_a[4]),    32'd50);
    check("t3_b0_g8", 32'(cap_b[8][0]), 32'd60);
    check("t3_b2_g8", 32'(cap_b[8][2]), 32'd50);

    // 4: flat window satisfies both tests
    fill(8'd77, 8'd77);
    run_one();
    check_result("t4", 1'b1, 1'b1);
    check("t4_b2_g8", 32'(cap_b[8][2]), 32'd77);
    check("t4_idle_a",  32'(oCmp_a),  32'd0);
    check("t4_idle_b0", 32'(oCmp_b0), 32'd0);
    check("t4_idle_b2", 32'(oCmp_b2), 32'd0);

    // 5: back-to-back with iValid held high
    fill(8'd10, 8'd20);
    iValid = 1'b1;
    step();
    fill(8'd30, 8'd20);
    np = 0; rlow = 0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 13) iValid = 1'b0;
      if (c <= 12 && !oReady) rlow++;
      if (c == 22) check("t5_hold_min", 32'(oIsMin), 32'd1);
      if (oValid) begin
        if (np < 2) begin
          pc[np]   = c;
          pmin[np] = oIsMin;
          pmax[np] = oIsMax;
        end
        np++;
      end
      step();
    end
    check("t5_pulses", 32'(np),   32'd2);
    check("t5_rlow",   32'(rlow), 32'd11);
    check("t5_p0_cyc", 32'(pc[0]), 32'd11);
    check("t5_p1_cyc", 32'(pc[1]), 32'd23);
    check("t5_p0_min", 32'(pmin[0]), 32'd1);
    check("t5_p0_max", 32'(pmax[0]), 32'd0);
    check("t5_p1_min", 32'(pmin[1]), 32'd0);
    check("t5_p1_max", 32'(pmax[1]), 32'd1);

    // 6: reset mid-operation aborts without a strobe
    fill(8'd10, 8'd20);
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    vcount = 0;
    for (int c = 1; c < 5; c++) begin
      if (oValid) vcount++;
      step();
    end
    rst = 1'b1;
    step();
    check("t6_ready", 32'(oReady), 32'd1);
    check("t6_valid", 32'(oValid), 32'd0);
    check("t6_min",   32'(oIsMin), 32'd0);
    check("t6_max",   32'(oIsMax), 32'd0);
    check("t6_cmp_a", 32'(oCmp_a), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (oValid) vcount++;
      step();
    end
    check("t6_no_strobe", 32'(vcount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
